// File: rtl/sid_bus_if_pkg.sv
// Shared constants and types for the SID CPU bus front end.
// Build option: SID_BUS_DECAY_EN selects the data-bus leakage model.
package sid_pkg;

  localparam logic [4:0] SID_ADDR_POTX = 5'd25;
  localparam logic [4:0] SID_ADDR_POTY = 5'd26;
  localparam logic [4:0] SID_ADDR_OSC3 = 5'd27;
  localparam logic [4:0] SID_ADDR_ENV3 = 5'd28;
  localparam int         SID_NUM_REGS  = 29;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } sid_bus_state_t;

endpackage

// File: rtl/sid_bus_if_if.sv
// 6502-style CPU bus seen by the SID: the CPU (master) drives phase, select,
// direction, address and write data; the SID (slave) returns read data.
interface sid_cpu_bus;
  import sid_pkg::*;

  logic       phi2;
  logic       cs_n;
  logic       rw;
  logic [4:0] addr;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (output phi2, cs_n, rw, addr, d_in, input d_out, d_oe);
  modport slave  (input phi2, cs_n, rw, addr, d_in, output d_out, d_oe);

endinterface

// File: rtl/sid_bus_if_decay.sv
// Bus leakage latch: holds the last bus value and clears it to 0x00 after
// DECAY_CYCLES clocks without a completed access. Used under SID_BUS_DECAY_EN.
module sid_bus_decay
  import sid_pkg::*;
#(
  parameter int DECAY_CYCLES = 2000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] latch
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       latch_q, latch_d;

  // A reload takes priority over an expiry landing in the same cycle.
  always_comb begin
    cnt_d   = cnt_q;
    latch_d = latch_q;
    if (load) begin
      cnt_d   = CNT_W'(DECAY_CYCLES);
      latch_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        latch_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      latch_q <= 8'h00;
    end else begin
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

  assign latch = latch_q;

endmodule

// File: rtl/sid_bus_if.sv
// CPU-side bus front end for the SID register block: turns phi2 bus cycles
// into write strobes and read data. SID_BUS_DECAY_EN enables bus leakage.
module sid_bus_if
  import sid_pkg::*;
#(
  parameter int DECAY_CYCLES = 2000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  sid_cpu_bus.slave  bus,
  input  logic [7:0] potx,
  input  logic [7:0] poty,
  input  logic [7:0] osc3,
  input  logic [7:0] env3,
  output logic       w_en,
  output logic [4:0] w_addr,
  output logic [7:0] w_data
);

  sid_bus_state_t state_q, state_d;
  logic       phi2_q;
  logic [7:0] d_out_q, d_out_d;
  logic       d_oe_q, d_oe_d;
  logic       w_en_q, w_en_d;
  logic [4:0] w_addr_q, w_addr_d;
  logic [7:0] w_data_q, w_data_d;
  logic       latch_load;
  logic [7:0] latch_val;
  logic [7:0] bus_latch;
  logic [7:0] rd_mux;
  logic       rise, fall;

  assign rise = bus.phi2 & ~phi2_q;
  assign fall = ~bus.phi2 & phi2_q;

`ifdef SID_BUS_DECAY_EN
  sid_bus_decay #(
    .DECAY_CYCLES (DECAY_CYCLES),
    .CNT_W        (CNT_W)
  ) u_decay (
    .clk      (clk),
    .rst      (rst),
    .load     (latch_load),
    .load_val (latch_val),
    .latch    (bus_latch)
  );
`else
  logic [CNT_W+8:0] unused_decay;
  assign unused_decay = {latch_load, latch_val, CNT_W'(DECAY_CYCLES)};
  assign bus_latch    = 8'h00;
`endif

  always_comb begin
    case (bus.addr)
      SID_ADDR_POTX: rd_mux = potx;
      SID_ADDR_POTY: rd_mux = poty;
      SID_ADDR_OSC3: rd_mux = osc3;
      SID_ADDR_ENV3: rd_mux = env3;
      default:       rd_mux = bus_latch;
    endcase
  end

  // Address/direction are taken only at the phi2 rise; read data is snapshotted
  // there too, so later source changes cannot tear the value the CPU sees.
  always_comb begin
    state_d    = state_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    w_en_d     = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    latch_load = 1'b0;
    latch_val  = 8'h00;
    case (state_q)
      IDLE: begin
        if (rise && !bus.cs_n) begin
          if (bus.rw) begin
            state_d = READ;
            d_out_d = rd_mux;
            d_oe_d  = 1'b1;
          end else begin
            state_d  = WRITE;
            w_addr_d = bus.addr;
            w_data_d = bus.d_in;
          end
        end
      end
      READ: begin
        if (fall) begin
          state_d    = IDLE;
          d_oe_d     = 1'b0;
          latch_load = 1'b1;
          latch_val  = d_out_q;
        end
      end
      WRITE: begin
        if (fall) begin
          state_d    = IDLE;
          w_en_d     = 1'b1;
          latch_load = 1'b1;
          latch_val  = w_data_q;
        end else if (bus.phi2) begin
          w_data_d = bus.d_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // phi2_q resets high so a phi2 already high at reset release is not a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phi2_q   <= 1'b1;
      d_out_q  <= 8'h00;
      d_oe_q   <= 1'b0;
      w_en_q   <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      phi2_q   <= bus.phi2;
      d_out_q  <= d_out_d;
      d_oe_q   <= d_oe_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.d_oe  = d_oe_q;
  assign w_en      = w_en_q;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;

endmodule

// File: doc/sid_bus_if.md
Name: sid_bus_if

Overview:
- CPU-side bus front end for the SID register block; the bus-facing end of the register write interface.
- Samples 6502-style bus cycles (phi2, cs_n, rw, addr, data) in the clk domain.
- Produces single-cycle register write strobes and serves reads of the four read-only registers (POTX, POTY, OSC3, ENV3).
- Models SID data-bus leakage: reads of write-only or unused addresses return the last bus value, which decays to zero after a programmable idle time.

Parameters:
- DECAY_CYCLES, 2000, clk cycles with no completed access before the bus latch clears to 0x00; legal range 1..65535.
- CNT_W, 16, decay counter width; must hold DECAY_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- phi2  input  1  CPU phase-2 clock level, already synchronous to clk.
- cs_n  input  1  chip select, active low; sampled only at the phi2 rising edge.
- rw  input  1  1 = read, 0 = write; sampled at the phi2 rising edge.
- addr  input  5  register address; sampled at the phi2 rising edge.
- d_in  input  8  CPU write data.
- potx, poty, osc3, env3  input  8 each  read-only register sources.
- d_out  output  8  read data.
- d_oe  output  1  read data drive enable.
- w_en  output  1  one-cycle register write strobe.
- w_addr  output  5  write address.
- w_data  output  8  write data.

Behaviour:
- Reset values: d_out=0, d_oe=0, w_en=0, w_addr=0, w_data=0, bus latch=0, decay counter=0, state IDLE, phi2_q=1.
  - Because phi2_q resets to 1, a phi2 held high through reset release is not seen as a rising edge.
- Edge detection: rise = phi2 & ~phi2_q; fall = ~phi2 & phi2_q; phi2_q is registered every cycle.
- States: IDLE, READ, WRITE.
- IDLE:
  - rise with cs_n=0, rw=1: go to READ. Read mux is evaluated from addr in the rise cycle (coherent snapshot). d_out takes that value and d_oe=1 from the next cycle.
  - rise with cs_n=0, rw=0: go to WRITE; latch addr.
  - rise with cs_n=1: stay in IDLE.
- READ:
  - Holds d_out/d_oe while phi2 is high. Changes on source inputs during phi2 high are ignored.
  - On fall: d_oe=0 in the next cycle, go to IDLE. Bus latch takes d_out; decay counter reloads.
- WRITE:
  - Captures d_in every cycle phi2 is high (the last high cycle wins).
  - On fall: next cycle w_en=1 for exactly one cycle with w_addr/w_data; return to IDLE. Bus latch takes w_data; counter reloads.
- Read map:
  - 25 = potx, 26 = poty, 27 = osc3, 28 = env3.
  - 0..24 and 29..31 return the bus latch.
- cs_n, rw and addr changes during phi2 high do not affect an in-progress access.
- A write strobe is generated for any address. The register block ignores read-only addresses.
- Decay:
  - Counter reloads to DECAY_CYCLES on each completed access.
  - Otherwise it decrements while nonzero.
  - On the 1->0 transition the bus latch clears to 0x00.
  - If a reload and the expiry fall in the same cycle, the reload wins and the latch is updated, not cleared.
- Reset asserted mid-access: abort. No w_en is issued, d_oe drops the next cycle, and all state returns to reset values.
- Back-to-back accesses: a rise in the same cycle that w_en is high is accepted.

Optional Feature:
- Macro SID_BUS_DECAY_EN.
- Defined: bus-latch leakage and decay as specified above.
- Undefined: no latch or counter is instantiated. Reads of 0..24 and 29..31 return 0x00; DECAY_CYCLES is unused.

Decomposition:
- Package sid_pkg holds:
  - Address constants SID_ADDR_POTX=25, SID_ADDR_POTY=26, SID_ADDR_OSC3=27, SID_ADDR_ENV3=28, SID_NUM_REGS=29.
  - State enum sid_bus_state_t {IDLE, READ, WRITE}.
- One sub-module, sid_bus_decay: holds the bus latch and decay counter, with load strobe, load value and latch output. Instantiated only under SID_BUS_DECAY_EN.

Test Plan:
- Write cycle: phi2 high 4 clk, cs_n=0, rw=0, addr=4, d_in=0x41 -> one w_en pulse 1 cycle after fall, w_addr=4, w_data=0x41; no d_oe.
- Read of osc3=0x5A: osc3 changes to 0x00 mid-phi2 -> d_out=0x5A, d_oe=1 from rise+1 through fall; d_oe=0 at fall+1.
- Leakage (DECAY_CYCLES=10, macro on): write 0x33 to addr 0, then read addr 3 within 5 cycles -> 0x33. Read again after 12 idle cycles -> 0x00.
- Macro off: same sequence -> both reads return 0x00.
- cs_n=1 at rise, then 0 during phi2 high -> no w_en, d_oe stays 0. Reset asserted during WRITE phi2 high -> no w_en, all outputs 0.
- Reset release with phi2 already high -> no access starts. The next genuine rise with cs_n=0, rw=1, addr=25, potx=0x7F -> d_out=0x7F.
